// File: rtl/debounce_edge.sv
// Push-button debouncer: two-flop synchronizer, 4-state qualification FSM,
// registered level/edge strobes, busy flag and a wrapping press counter.
module debounce_edge #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_WIDTH       = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_in,
   output logic       level_out,
   output logic       rise_pulse,
   output logic       fall_pulse,
   output logic       busy,
   output logic [7:0] press_count
);

   localparam logic [1:0] STABLE_LO = 2'd0;
   localparam logic [1:0] QUAL_HI   = 2'd1;
   localparam logic [1:0] STABLE_HI = 2'd2;
   localparam logic [1:0] QUAL_LO   = 2'd3;

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   logic                 sync1, sync_q;
   logic [1:0]           state, state_d;
   logic [CNT_WIDTH-1:0] cnt, cnt_d;
   logic                 level_d, rise_d, fall_d, busy_d;
   logic [7:0]           count_d;

   // NOTE: every variable gets a default before the case so no path leaves
   // one unassigned; otherwise synthesis would infer a latch.
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      level_d = level_out;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      count_d = press_count;
      case (state)
         STABLE_LO: begin
            if (sync_q) begin
               state_d = QUAL_HI;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d = '0;
            end
         end
         QUAL_HI: begin
            if (!sync_q) begin
               state_d = STABLE_LO;
               cnt_d   = '0;
            end else if (cnt == CNT_LAST) begin
               state_d = STABLE_HI;
               cnt_d   = '0;
               level_d = 1'b1;
               rise_d  = 1'b1;
               count_d = press_count + 8'd1;
            end else begin
               cnt_d = cnt + CNT_ONE;
            end
         end
         STABLE_HI: begin
            if (!sync_q) begin
               state_d = QUAL_LO;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d = '0;
            end
         end
         QUAL_LO: begin
            if (sync_q) begin
               state_d = STABLE_HI;
               cnt_d   = '0;
            end else if (cnt == CNT_LAST) begin
               state_d = STABLE_LO;
               cnt_d   = '0;
               level_d = 1'b0;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt + CNT_ONE;
            end
         end
         default: begin
            state_d = STABLE_LO;
            cnt_d   = '0;
         end
      endcase
   end

   // busy is registered from the next state so it tracks the QUAL states exactly.
   assign busy_d = (state_d == QUAL_HI) || (state_d == QUAL_LO);

   // NOTE: sequential state uses non-blocking assignments so all flops update
   // together on the edge, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1       <= 1'b0;
         sync_q      <= 1'b0;
         state       <= STABLE_LO;
         cnt         <= '0;
         level_out   <= 1'b0;
         rise_pulse  <= 1'b0;
         fall_pulse  <= 1'b0;
         busy        <= 1'b0;
         press_count <= 8'd0;
      end else begin
         sync1       <= btn_in;
         sync_q      <= sync1;
         state       <= state_d;
         cnt         <= cnt_d;
         level_out   <= level_d;
         rise_pulse  <= rise_d;
         fall_pulse  <= fall_d;
         busy        <= busy_d;
         press_count <= count_d;
      end
   end

endmodule

// File: doc/debounce_edge.md
DEBOUNCE_EDGE -- requirements
Module: debounce_edge

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized samples needed to accept a new level; legal range 2..65535.
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of the internal stability counter; 2^CNT_WIDTH > DEBOUNCE_CYCLES.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port btn_in  input  1  raw asynchronous, bouncy input (push-button/switch).
REQ-006 SHALL have port level_out  output  1  debounced level; feeds the downstream D flip-flop stage directly.
REQ-007 SHALL have port rise_pulse  output  1  one-cycle strobe on an accepted 0->1 change.
REQ-008 SHALL have port fall_pulse  output  1  one-cycle strobe on an accepted 1->0 change.
REQ-009 SHALL have port busy  output  1  high while a candidate level change is being qualified.
REQ-010 SHALL have port press_count  output  8  count of accepted rising changes.

Function
REQ-011 SHALL pass btn_in through a two-flop synchronizer (sync1, then sync_q); only sync_q is used by the FSM.
REQ-012 SHALL implement a 4-state FSM: STABLE_LO, QUAL_HI, STABLE_HI, QUAL_LO.
REQ-013 In STABLE_LO with sync_q=1: go to QUAL_HI, cnt=1. With sync_q=0: stay, cnt=0.
REQ-014 In QUAL_HI with sync_q=0: return to STABLE_LO, cnt=0, no pulse; bounce discards all progress.
REQ-015 In QUAL_HI with sync_q=1 and cnt=DEBOUNCE_CYCLES-1: go to STABLE_HI, cnt=0, level_out<=1, rise_pulse<=1, press_count<=press_count+1.
REQ-016 In QUAL_HI with sync_q=1 and cnt<DEBOUNCE_CYCLES-1: cnt<=cnt+1.
REQ-017 STABLE_HI/QUAL_LO SHALL mirror REQ-013..016 with polarity inverted: level_out<=0, fall_pulse<=1, press_count unchanged.
REQ-018 A level SHALL be accepted after exactly DEBOUNCE_CYCLES consecutive equal sync_q samples, counting the sample that left the STABLE state.
REQ-019 Latency: with btn_in first sampled high at edge E0 and held, level_out and rise_pulse SHALL be high after edge E(DEBOUNCE_CYCLES+1).
REQ-020 rise_pulse and fall_pulse SHALL be registered, high exactly one cycle per accepted change, and never high together.
REQ-021 busy SHALL be registered, high exactly while the FSM is in QUAL_HI or QUAL_LO.
REQ-022 press_count SHALL wrap 255->0 without saturation or flag.
REQ-023 level_out SHALL change only on accepted changes, never directly from btn_in or sync1.
REQ-024 All outputs SHALL be registered; no combinational path from btn_in to any output.

Reset
REQ-025 While rst_n=0, regardless of clk: sync1=0, sync_q=0, state=STABLE_LO, cnt=0, level_out=0, rise_pulse=0, fall_pulse=0, busy=0, press_count=0.
REQ-026 Reset asserted mid-qualification SHALL abort it with no pulse; after release, qualification restarts from STABLE_LO.
REQ-027 If btn_in is high at reset release, a rise SHALL be accepted per REQ-019, counting from the first edge after release.

Verification
REQ-028 DEBOUNCE_CYCLES=4, btn_in 0->1 held: rise_pulse high for one cycle after the 6th edge (E5), level_out=1 from then on, press_count=1.
REQ-029 btn_in high for 3 sampled cycles, low 1, then held high: no pulse during the bounce; busy drops to 0; rise_pulse after E5 counted from the restart; press_count=1.
REQ-030 With level_out=1, btn_in 1->0 held: fall_pulse one cycle after E5, level_out=0, press_count unchanged.
REQ-031 256 clean press/release cycles: press_count returns to 0; rise_pulse and fall_pulse each seen exactly 256 times.
REQ-032 rst_n pulsed low between clock edges while in QUAL_HI: all outputs 0 immediately; no rise_pulse; with btn_in held high, rise_pulse after E5 counted from the first edge after release.
REQ-033 Single-cycle btn_in glitches, each followed by at least one low sample: level_out stays 0, no pulses, busy toggles per glitch.
